// File: rtl/alu.sv
// Registered 8-function ALU: one result per clock, one cycle of latency.
// Build macro ALU_MUL_EN enables the multiplier on opcode 010; without it that opcode loads zero.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPERATIONCODE,
  output logic [WIDTH-1:0] O
);

  // Interface: no handshake. Inputs are sampled on every rising clk edge and
  // their result is visible on O from that edge until the next one.

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] next_o;
  logic [WIDTH-1:0] mul_lo;
  logic             slt_bit;

  assign op      = op_e'(OPERATIONCODE);
  assign slt_bit = ($signed(A) < $signed(B));

`ifdef ALU_MUL_EN
  // Only the low WIDTH bits of the unsigned product are kept.
  assign mul_lo = A * B;
`else
  assign mul_lo = '0;
`endif

  always_comb begin
    next_o = '0;
    case (op)
      OP_ADD: next_o = A + B;
      OP_SUB: next_o = A - B;
      OP_MUL: next_o = mul_lo;
      OP_AND: next_o = A & B;
      OP_OR:  next_o = A | B;
      OP_XOR: next_o = A ^ B;
      OP_NOT: next_o = ~A;
      OP_SLT: next_o = {{(WIDTH-1){1'b0}}, slt_bit};
      default: next_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O <= '0;
    end else begin
      O <= next_o;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, each opcode, wrap cases, async reset and back-to-back issue.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] o;

  int vec_count;
  int err_count;

  logic [W-1:0] exp_q[$];

`ifdef ALU_MUL_EN
  localparam logic [W-1:0] MUL_BIG   = 32'h0003_0000;
  localparam logic [W-1:0] MUL_SMALL = 32'h0000_003C;
`else
  localparam logic [W-1:0] MUL_BIG   = 32'h0;
  localparam logic [W-1:0] MUL_SMALL = 32'h0;
`endif

  alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .OPERATIONCODE(op),
    .O(o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present inputs on the falling edge, return just after the next rising edge
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic [2:0] dop);
    @(negedge clk);
    a  = da;
    b  = db;
    op = dop;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    op = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    vec_count++;
    if (o !== 32'h0) begin
      $display("FAIL reset_hold: got %h want %h", o, 32'h0);
      err_count++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec_count++;
    if (o !== 32'h2345_6789) begin
      $display("FAIL reset_release: got %h want %h", o, 32'h2345_6789);
      err_count++;
    end
  endtask

  task automatic test_not();
    drive(32'hCD0A_D074, 32'hDEAD_BEEF, 3'b110);
    vec_count++;
    if (o !== 32'h32F5_2F8B) begin
      $display("FAIL not_1: got %h want %h", o, 32'h32F5_2F8B);
      err_count++;
    end
    drive(32'h34EB_5103, 32'h0, 3'b110);
    vec_count++;
    if (o !== 32'hCB14_AEFC) begin
      $display("FAIL not_2: got %h want %h", o, 32'hCB14_AEFC);
      err_count++;
    end
  endtask

  task automatic test_wrap();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
    vec_count++;
    if (o !== 32'h0) begin
      $display("FAIL add_wrap: got %h want %h", o, 32'h0);
      err_count++;
    end
    drive(32'h0, 32'h0000_0001, 3'b001);
    vec_count++;
    if (o !== 32'hFFFF_FFFF) begin
      $display("FAIL sub_wrap: got %h want %h", o, 32'hFFFF_FFFF);
      err_count++;
    end
  endtask

  task automatic test_logic();
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011);
    vec_count++;
    if (o !== 32'hF000_F000) begin
      $display("FAIL and: got %h want %h", o, 32'hF000_F000);
      err_count++;
    end
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
    vec_count++;
    if (o !== 32'hFFF0_FFF0) begin
      $display("FAIL or: got %h want %h", o, 32'hFFF0_FFF0);
      err_count++;
    end
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
    vec_count++;
    if (o !== 32'h0FF0_0FF0) begin
      $display("FAIL xor: got %h want %h", o, 32'h0FF0_0FF0);
      err_count++;
    end
  endtask

  task automatic test_mul_slt();
    drive(32'h0001_0000, 32'h0001_0003, 3'b010);
    vec_count++;
    if (o !== MUL_BIG) begin
      $display("FAIL mul: got %h want %h", o, MUL_BIG);
      err_count++;
    end
    drive(32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
    vec_count++;
    if (o !== 32'h1) begin
      $display("FAIL slt_neg: got %h want %h", o, 32'h1);
      err_count++;
    end
    drive(32'h0000_0001, 32'hFFFF_FFFF, 3'b111);
    vec_count++;
    if (o !== 32'h0) begin
      $display("FAIL slt_swap: got %h want %h", o, 32'h0);
      err_count++;
    end
    drive(32'h8000_0000, 32'h7FFF_FFFF, 3'b111);
    vec_count++;
    if (o !== 32'h1) begin
      $display("FAIL slt_extreme: got %h want %h", o, 32'h1);
      err_count++;
    end
  endtask

  // opcode changes between edges must not reach O early
  task automatic test_hold();
    drive(32'h0000_0003, 32'h0000_0004, 3'b000);
    #2;
    op = 3'b110;
    a  = 32'h0;
    #1;
    vec_count++;
    if (o !== 32'h0000_0007) begin
      $display("FAIL hold_between_edges: got %h want %h", o, 32'h0000_0007);
      err_count++;
    end
    @(posedge clk);
    #1;
    vec_count++;
    if (o !== 32'hFFFF_FFFF) begin
      $display("FAIL hold_next_edge: got %h want %h", o, 32'hFFFF_FFFF);
      err_count++;
    end
  endtask

  task automatic test_async_reset();
    drive(32'h0, 32'h0, 3'b110);
    #2;
    rst = 1'b1;
    #1;
    vec_count++;
    if (o !== 32'h0) begin
      $display("FAIL async_reset_clear: got %h want %h", o, 32'h0);
      err_count++;
    end
    @(posedge clk);
    #1;
    vec_count++;
    if (o !== 32'h0) begin
      $display("FAIL async_reset_held: got %h want %h", o, 32'h0);
      err_count++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec_count++;
    if (o !== 32'hFFFF_FFFF) begin
      $display("FAIL async_reset_release: got %h want %h", o, 32'hFFFF_FFFF);
      err_count++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_tab [8];
    logic [W-1:0] want;
    exp_tab[0] = 32'h0000_0011;
    exp_tab[1] = 32'h0000_0007;
    exp_tab[2] = MUL_SMALL;
    exp_tab[3] = 32'h0000_0004;
    exp_tab[4] = 32'h0000_000D;
    exp_tab[5] = 32'h0000_0009;
    exp_tab[6] = 32'hFFFF_FFF3;
    exp_tab[7] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_tab[i]);
      drive(32'h0000_000C, 32'h0000_0005, 3'(i));
      want = exp_q.pop_front();
      vec_count++;
      if (o !== want) begin
        $display("FAIL b2b_op%0d: got %h want %h", i, o, want);
        err_count++;
      end
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    test_reset();
    test_not();
    test_wrap();
    test_logic();
    test_mul_slt();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; all values below assume WIDTH=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 OPERATIONCODE  input  3  operation select.
REQ-007 O  output  WIDTH  registered result.

Function
REQ-008 O SHALL be a register loaded on every rising clk edge with f(A, B, OPERATIONCODE) sampled at that edge; latency 1 cycle, no handshake, a new operation is accepted every cycle.
REQ-009 Opcode 000 ADD: O = (A + B) mod 2^WIDTH; carry out discarded.
REQ-010 Opcode 001 SUB: O = (A - B) mod 2^WIDTH; borrow discarded; 0 - 1 = 0xFFFFFFFF.
REQ-011 Opcode 010 MUL: O = low WIDTH bits of the unsigned product A*B; upper bits discarded (see REQ-020).
REQ-012 Opcode 011 AND: O = A & B, bitwise.
REQ-013 Opcode 100 OR: O = A | B, bitwise.
REQ-014 Opcode 101 XOR: O = A ^ B, bitwise.
REQ-015 Opcode 110 NOT: O = ~A, bitwise; B ignored.
REQ-016 Opcode 111 SLT: O = 1 if A < B as signed two's complement, else 0 (bits WIDTH-1:1 zero).
REQ-017 Operands or opcode containing X/Z SHALL NOT be specially handled; no other opcode exists, all 8 codes are defined.
REQ-018 Changing OPERATIONCODE between edges SHALL have no effect on O until the next rising edge.

Reset
REQ-019 While rst=1, O SHALL be 0 immediately (asynchronous) and remain 0 regardless of clk; on the first rising edge after rst falls, O takes the result of the inputs at that edge; reset mid-stream discards the pending result.

Configuration
REQ-020 Macro ALU_MUL_EN: when defined, opcode 010 implements MUL per REQ-011; when undefined, no multiplier is synthesized and opcode 010 SHALL load O = 0; all other opcodes identical in both builds.

Verification
REQ-021 NOT: A=0xCD0AD074, OPERATIONCODE=110, any B -> after one edge O=0x32F52F8B; A=0x34EB5103 -> O=0xCB14AEFC.
REQ-022 ADD/SUB wrap: A=0xFFFFFFFF, B=0x00000001, op 000 -> O=0x00000000; A=0, B=1, op 001 -> O=0xFFFFFFFF.
REQ-023 Logic: A=0xF0F0F0F0, B=0xFF00FF00 -> op 011 O=0xF000F000, op 100 O=0xFFF0FFF0, op 101 O=0x0FF00FF0.
REQ-024 MUL/SLT: A=0x00010000, B=0x00010003, op 010 -> O=0x00030000 (with ALU_MUL_EN) or 0 (without); A=0xFFFFFFFF, B=1, op 111 -> O=1; swapped -> O=0.
REQ-025 Reset: drive op 110, A=0; assert rst asynchronously mid-cycle -> O=0 without a clock edge; deassert -> O=0xFFFFFFFF after next edge.
REQ-026 Back-to-back: change opcode every cycle across all 8 codes -> each result appears exactly one edge after its inputs, no bubbles.
